// File: rtl/sa_cache_ctrl.sv
// sa_cache_ctrl: two-way set-associative, write-back, write-allocate cache
// controller sitting between the CPU and main memory.
//  - per-set LRU bit, word-granular CPU writes merged into the resident line
//  - valid/ready line-wide memory handshake, one-cycle CPU response pulse
//  - optional hit/miss counters, compiled in when CACHE_STATS_EN is defined
module sa_cache_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 1024,
  localparam int LINE_W    = WORD_W * LINE_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid_i,
  input  logic              cpu_req_rw_i,
  input  logic [ADDR_W-1:0] cpu_req_addr_i,
  input  logic [WORD_W-1:0] cpu_req_wdata_i,
  output logic              cpu_ready_o,
  output logic              cpu_resp_valid_o,
  output logic [WORD_W-1:0] cpu_rdata_o,
  output logic              mem_req_valid_o,
  output logic              mem_req_rw_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [LINE_W-1:0] mem_req_wdata_o,
  input  logic              mem_req_ready_i,
  input  logic [LINE_W-1:0] mem_req_rdata_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits_o,
  output logic [31:0]       stat_misses_o
`endif
);

  localparam int BOFF_W = $clog2(WORD_W / 8);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WSEL_W + BOFF_W;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITE_BACK,
    S_ALLOCATE
  } state_t;

  state_t                state_q;
  logic                  cpu_ready_q;
  logic                  cpu_resp_valid_q;
  logic [WORD_W-1:0]     cpu_rdata_q;
  logic                  mem_req_valid_q;
  logic                  mem_req_rw_q;
  logic [ADDR_W-1:0]     mem_req_addr_q;
  logic [LINE_W-1:0]     mem_req_wdata_q;

  // Latched request and miss bookkeeping
  logic [ADDR_W-1:0]     addr_q;
  logic [WORD_W-1:0]     wdata_q;
  logic                  rw_q;
  logic                  first_q;     // first COMPARE pass of this request
  logic                  victim_q;

  // Per-set state bits; these need a reset so they live outside the RAMs
  logic [1:0][SETS-1:0]  valid_q;
  logic [1:0][SETS-1:0]  dirty_q;
  logic [SETS-1:0]       lru_q;       // way to evict next when both are valid

`ifdef CACHE_STATS_EN
  logic [31:0]           hits_q;
  logic [31:0]           misses_q;
`endif

  // Registered RAM read ports, one per way
  logic [TAG_W-1:0]      rd_tag  [2];
  logic [LINE_W-1:0]     rd_line [2];

  logic                  accept;
  logic [IDX_W-1:0]      idx_in;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [WSEL_W-1:0]     wsel;
  logic [1:0]            way_valid;
  logic [1:0]            way_dirty;
  logic [1:0]            hit_way;
  logic                  hit;
  logic                  hit_sel;
  logic                  victim_d;
  logic                  victim_dirty;
  logic [LINE_W-1:0]     sel_line;
  logic [LINE_W-1:0]     merged_line;
  logic [WORD_W-1:0]     sel_words [LINE_WORDS];
  logic [WORD_W-1:0]     sel_word;
  logic [ADDR_W-1:0]     fill_addr;
  logic [ADDR_W-1:0]     wb_addr;
  logic                  unused_byte_bits;

  assign accept    = cpu_ready_q && cpu_req_valid_i;
  assign idx_in    = cpu_req_addr_i[IDX_W+OFF_W-1:OFF_W];
  assign idx       = addr_q[IDX_W+OFF_W-1:OFF_W];
  assign tag       = addr_q[ADDR_W-1:IDX_W+OFF_W];
  assign wsel      = addr_q[OFF_W-1:BOFF_W];
  assign unused_byte_bits = ^addr_q[BOFF_W-1:0];

  assign way_valid = {valid_q[1][idx], valid_q[0][idx]};
  assign way_dirty = {dirty_q[1][idx], dirty_q[0][idx]};
  assign hit_way[0] = way_valid[0] && (rd_tag[0] == tag);
  assign hit_way[1] = way_valid[1] && (rd_tag[1] == tag);
  assign hit       = |hit_way;
  assign hit_sel   = ~hit_way[0];

  // Invalid ways are filled first (way0 before way1), else the LRU way goes
  assign victim_d     = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[idx]);
  assign victim_dirty = way_valid[victim_d] && way_dirty[victim_d];

  assign sel_line  = rd_line[hit_sel];
  assign sel_word  = sel_words[wsel];
  assign fill_addr = {tag, idx, {OFF_W{1'b0}}};
  assign wb_addr   = {rd_tag[victim_d], idx, {OFF_W{1'b0}}};

  genvar gi;

  // Word view of the hit line and the line with the CPU write word merged in
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      assign sel_words[gi] = sel_line[gi*WORD_W +: WORD_W];
      assign merged_line[gi*WORD_W +: WORD_W] =
          (wsel == WSEL_W'(gi)) ? wdata_q : sel_line[gi*WORD_W +: WORD_W];
    end
  endgenerate

  // Tag and data RAMs per way; contents are not reset
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      logic [TAG_W-1:0]  tag_mem  [SETS];
      logic [LINE_W-1:0] data_mem [SETS];
      logic [TAG_W-1:0]  rd_tag_q;
      logic [LINE_W-1:0] rd_line_q;
      logic              fill_we;
      logic              hit_we;

      assign fill_we = (state_q == S_ALLOCATE) && mem_req_ready_i && (victim_q == 1'(gi));
      assign hit_we  = (state_q == S_COMPARE) && hit && rw_q && (hit_sel == 1'(gi));

      // Read the indexed set on accept; a fill also refreshes the read port
      // so the following re-compare sees the new line without a RAM access.
      always_ff @(posedge clk) begin
        if (fill_we) begin
          tag_mem[idx]  <= tag;
          data_mem[idx] <= mem_req_rdata_i;
          rd_tag_q      <= tag;
          rd_line_q     <= mem_req_rdata_i;
        end else if (hit_we) begin
          data_mem[idx] <= merged_line;
        end
        if (accept) begin
          rd_tag_q  <= tag_mem[idx_in];
          rd_line_q <= data_mem[idx_in];
        end
      end

      assign rd_tag[gi]  = rd_tag_q;
      assign rd_line[gi] = rd_line_q;
    end
  endgenerate

  // Main controller FSM with registered CPU/memory outputs and per-set state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cpu_ready_q      <= 1'b0;
      cpu_resp_valid_q <= 1'b0;
      cpu_rdata_q      <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_req_rw_q     <= 1'b0;
      mem_req_addr_q   <= '0;
      mem_req_wdata_q  <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      rw_q             <= 1'b0;
      first_q          <= 1'b0;
      victim_q         <= 1'b0;
      valid_q          <= '0;
      dirty_q          <= '0;
      lru_q            <= '0;
`ifdef CACHE_STATS_EN
      hits_q           <= '0;
      misses_q         <= '0;
`endif
    end else begin
      cpu_resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cpu_ready_q <= 1'b1;
          if (accept) begin
            addr_q      <= cpu_req_addr_i;
            wdata_q     <= cpu_req_wdata_i;
            rw_q        <= cpu_req_rw_i;
            first_q     <= 1'b1;
            cpu_ready_q <= 1'b0;
            state_q     <= S_COMPARE;
          end
        end

        S_COMPARE: begin
          first_q <= 1'b0;
`ifdef CACHE_STATS_EN
          if (first_q) begin
            if (hit) begin
              if (hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
            end else begin
              if (misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
            end
          end
`endif
          if (hit) begin
            if (rw_q) begin
              dirty_q[hit_sel][idx] <= 1'b1;
            end else begin
              cpu_rdata_q <= sel_word;
            end
            lru_q[idx]       <= ~hit_sel;
            cpu_resp_valid_q <= 1'b1;
            cpu_ready_q      <= 1'b1;
            state_q          <= S_IDLE;
          end else begin
            victim_q        <= victim_d;
            mem_req_valid_q <= 1'b1;
            if (victim_dirty) begin
              mem_req_rw_q    <= 1'b1;
              mem_req_addr_q  <= wb_addr;
              mem_req_wdata_q <= rd_line[victim_d];
              state_q         <= S_WRITE_BACK;
            end else begin
              mem_req_rw_q    <= 1'b0;
              mem_req_addr_q  <= fill_addr;
              state_q         <= S_ALLOCATE;
            end
          end
        end

        S_WRITE_BACK: begin
          if (mem_req_ready_i) begin
            dirty_q[victim_q][idx] <= 1'b0;
            mem_req_rw_q           <= 1'b0;
            mem_req_addr_q         <= fill_addr;
            state_q                <= S_ALLOCATE;
          end
        end

        S_ALLOCATE: begin
          if (mem_req_ready_i) begin
            valid_q[victim_q][idx] <= 1'b1;
            dirty_q[victim_q][idx] <= 1'b0;
            mem_req_valid_q        <= 1'b0;
            state_q                <= S_COMPARE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_ready_o      = cpu_ready_q;
  assign cpu_resp_valid_o = cpu_resp_valid_q;
  assign cpu_rdata_o      = cpu_rdata_q;
  assign mem_req_valid_o  = mem_req_valid_q;
  assign mem_req_rw_o     = mem_req_rw_q;
  assign mem_req_addr_o   = mem_req_addr_q;
  assign mem_req_wdata_o  = mem_req_wdata_q;
`ifdef CACHE_STATS_EN
  assign stat_hits_o      = hits_q;
  assign stat_misses_o    = misses_q;
`endif

endmodule
